// File: rtl/ws_sequencer_pkg.sv
// Shared definitions for the weight-stationary sequencer: inst word bit positions,
// the FSM state type and the idle instruction.
package ws_sequencer_pkg;

  localparam int unsigned INST_W        = 35;
  localparam int unsigned INST_MODE     = 34;
  localparam int unsigned INST_ACC      = 33;
  localparam int unsigned INST_CEN_P    = 32;
  localparam int unsigned INST_WEN_P    = 31;
  localparam int unsigned INST_AP_MSB   = 30;
  localparam int unsigned INST_AP_LSB   = 20;
  localparam int unsigned INST_CEN_X    = 19;
  localparam int unsigned INST_WEN_X    = 18;
  localparam int unsigned INST_AX_MSB   = 17;
  localparam int unsigned INST_AX_LSB   = 7;
  localparam int unsigned INST_OFIFO_RD = 6;
  localparam int unsigned INST_L0_RD    = 3;
  localparam int unsigned INST_L0_WR    = 2;
  localparam int unsigned INST_EXEC     = 1;
  localparam int unsigned INST_LOAD     = 0;

  // Both SRAMs deselected and in read mode, everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    StIdle,
    StWFetch,
    StWLoad,
    StAFetch,
    StExec,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ws_sequencer_if.sv
// Control handshake between the core top level and the weight-stationary sequencer.
interface ws_sequencer_if;
  import ws_sequencer_pkg::*;

  logic              start;
  logic              l0_full;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  l0_full,
    input  ofifo_valid,
    output inst,
    output busy,
    output done
  );

  modport slave (
    output start,
    output l0_full,
    output ofifo_valid,
    input  inst,
    input  busy,
    input  done
  );
endinterface

// File: rtl/ws_mem_fetch.sv
// xmem read-issue / L0 write engine shared by the weight and activation fetch phases.
// l0_wr follows each read by one cycle to cover the SRAM read latency.
module ws_mem_fetch #(
  parameter int unsigned addr_bw = 11,
  parameter int unsigned cnt_w   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               l0_full,
  input  logic [addr_bw-1:0] base,
  input  logic [cnt_w-1:0]   count,
  output logic               cen_xmem,
  output logic [addr_bw-1:0] a_xmem,
  output logic               l0_wr,
  output logic               fin
);

  logic               active_q;
  logic [cnt_w-1:0]   issued_q;
  logic [cnt_w-1:0]   written_q;
  logic               cen_q;
  logic [addr_bw-1:0] addr_q;
  logic               wr_q;
  logic [cnt_w-1:0]   issued_c;
  logic               can_issue;

  always_comb begin
    issued_c  = go ? '0 : issued_q;
    can_issue = (go | active_q) && (issued_c < count) && !l0_full;
  end

  assign fin      = wr_q && (written_q == count - cnt_w'(1));
  assign cen_xmem = cen_q;
  assign a_xmem   = addr_q;
  assign l0_wr    = wr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q  <= 1'b0;
      issued_q  <= '0;
      written_q <= '0;
      cen_q     <= 1'b1;
      addr_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      wr_q     <= ~cen_q;
      cen_q    <= ~can_issue;
      addr_q   <= can_issue ? base + addr_bw'(issued_c) : '0;
      issued_q <= can_issue ? issued_c + cnt_w'(1) : issued_c;
      if (go) begin
        active_q  <= 1'b1;
        written_q <= '0;
      end else if (fin) begin
        active_q  <= 1'b0;
        written_q <= '0;
      end else if (wr_q) begin
        written_q <= written_q + cnt_w'(1);
      end
    end
  end

endmodule

// File: rtl/ws_sequencer.sv
// Weight-stationary corelet sequencer: per kernel index fetch weights, load them, fetch and
// execute activations, then drain the OFIFO into pmem. The inst word is built purely from flops.
module ws_sequencer
  import ws_sequencer_pkg::*;
#(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned len_nij = 36,
  parameter int unsigned num_kij = 9,
  parameter int unsigned addr_bw = 11,
  parameter int unsigned w_base  = 0,
  parameter int unsigned a_base  = 128
) (
  input logic            clk,
  input logic            reset,
  ws_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(max3(col + row, len_nij, num_kij) + 1);

  state_e             state_q;
  logic [CntW-1:0]    kij_q;
  logic [CntW-1:0]    cnt_q;
  logic               go_q;
  logic               busy_q;
  logic               done_q;
  logic               l0_rd_q;
  logic               load_q;
  logic               exec_q;
  logic               ofifo_rd_q;
  logic               cen_p_q;
  logic               wen_p_q;
  logic [addr_bw-1:0] ap_q;

  logic [addr_bw-1:0] fetch_base;
  logic [CntW-1:0]    fetch_count;
  logic [addr_bw-1:0] pmem_addr;
  logic               x_cen;
  logic [addr_bw-1:0] x_addr;
  logic               x_wr;
  logic               fetch_fin;
  logic [INST_W-1:0]  inst_w;

  always_comb begin
    if (state_q == StAFetch) begin
      fetch_base  = addr_bw'(a_base);
      fetch_count = CntW'(len_nij);
    end else begin
      fetch_base  = addr_bw'(w_base) + addr_bw'(kij_q) * addr_bw'(col);
      fetch_count = CntW'(col);
    end
    pmem_addr = addr_bw'(kij_q) * addr_bw'(len_nij) + addr_bw'(cnt_q);
  end

  ws_mem_fetch #(
    .addr_bw(addr_bw),
    .cnt_w  (CntW)
  ) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .go      (go_q),
    .l0_full (bus.l0_full),
    .base    (fetch_base),
    .count   (fetch_count),
    .cen_xmem(x_cen),
    .a_xmem  (x_addr),
    .l0_wr   (x_wr),
    .fin     (fetch_fin)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      kij_q      <= '0;
      cnt_q      <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      l0_rd_q    <= 1'b0;
      load_q     <= 1'b0;
      exec_q     <= 1'b0;
      ofifo_rd_q <= 1'b0;
      cen_p_q    <= 1'b1;
      wen_p_q    <= 1'b1;
      ap_q       <= '0;
    end else begin
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      ofifo_rd_q <= 1'b0;
      cen_p_q    <= 1'b1;
      wen_p_q    <= 1'b1;
      ap_q       <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StWFetch;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            kij_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StWFetch: begin
          if (fetch_fin) begin
            state_q <= StWLoad;
            cnt_q   <= '0;
            l0_rd_q <= 1'b1;
            load_q  <= 1'b1;
          end
        end
        StWLoad: begin
          // load_q doubles as the sub-phase flag: col load cycles, then col+row settle cycles.
          if (load_q) begin
            if (cnt_q == CntW'(col - 1)) begin
              cnt_q   <= '0;
              load_q  <= 1'b0;
              l0_rd_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else if (cnt_q == CntW'(col + row - 1)) begin
            cnt_q   <= '0;
            state_q <= StAFetch;
            go_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAFetch: begin
          if (fetch_fin) begin
            state_q <= StExec;
            cnt_q   <= '0;
            l0_rd_q <= 1'b1;
            exec_q  <= 1'b1;
          end
        end
        StExec: begin
          if (cnt_q == CntW'(len_nij - 1)) begin
            cnt_q   <= '0;
            l0_rd_q <= 1'b0;
            exec_q  <= 1'b0;
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          // ofifo_rd and the pmem write follow ofifo_valid as sampled at this edge.
          if (bus.ofifo_valid) begin
            ofifo_rd_q <= 1'b1;
            cen_p_q    <= 1'b0;
            wen_p_q    <= 1'b0;
            ap_q       <= pmem_addr;
            if (cnt_q == CntW'(len_nij - 1)) begin
              cnt_q <= '0;
              if (kij_q == CntW'(num_kij - 1)) begin
                state_q <= StDone;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                kij_q   <= kij_q + CntW'(1);
                state_q <= StWFetch;
                go_q    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    inst_w                          = '0;
    inst_w[INST_MODE]               = 1'b0;
    inst_w[INST_ACC]                = 1'b0;
    inst_w[INST_CEN_P]              = cen_p_q;
    inst_w[INST_WEN_P]              = wen_p_q;
    inst_w[INST_AP_MSB:INST_AP_LSB] = ap_q;
    inst_w[INST_CEN_X]              = x_cen;
    inst_w[INST_WEN_X]              = 1'b1;
    inst_w[INST_AX_MSB:INST_AX_LSB] = x_addr;
    inst_w[INST_OFIFO_RD]           = ofifo_rd_q;
    inst_w[INST_L0_RD]              = l0_rd_q;
    inst_w[INST_L0_WR]              = x_wr;
    inst_w[INST_EXEC]               = exec_q;
    inst_w[INST_LOAD]               = load_q;
  end

  assign bus.inst = inst_w;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
